neosd_card_cmd: RTL and testbench
=================================

# neosd_card_cmd

Card-side responder for the SD CMD line: the other end of the host command path. It sits behind an SD socket model or an FPGA SD-card emulator. It runs on the system clock and oversamples the host's SD clock. It receives 48-bit host commands and checks framing and CRC7, then hands index and argument to a user-side controller. It then transmits that controller's short (48-bit) or long (136-bit) response with correct NCR spacing.

## Interface
- `NCR_MIN`, 2: minimum number of SD-clock cycles between the command end bit and the response start bit.
- `NCR_MAX`, 64: SD-clock cycles to wait for a response strobe before abandoning the response.
- `clk_i` in 1: system clock; all logic on rising edge.
- `rst_i` in 1: reset; **synchronous, active-high**.
- `sd_clk_i` in 1: host SD clock, asynchronous; frequency ≤ f(clk_i)/4.
- `sd_cmd_i` in 1: CMD line input, asynchronous.
- `sd_cmd_o` out 1: CMD drive value.
- `sd_cmd_oe` out 1: CMD output enable.
- `cmd_valid_o` out 1: 1-cycle pulse; a good command has been received.
- `cmd_idx_o` out 6: command index; held until the next good command.
- `cmd_arg_o` out 32: command argument; held until the next good command.
- `resp_valid_i` in 1: response strobe; only accepted in WAIT.
- `resp_kind_i` in 2: 0 = none, 1 = short, 2 = long, 3 = none.
- `resp_data_i` in 128: for short, [37:32] is the index and [31:0] the argument; for long, [127:1] is sent verbatim (CRC included) and [0] is ignored.
- `busy_o` out 1: high in any state other than IDLE.
- `crc_err_o` out 1: 1-cycle pulse on a command CRC mismatch.
- `frame_err_o` out 1: 1-cycle pulse on a bad transmission bit or end bit.
- `resp_timeout_o` out 1: 1-cycle pulse when NCR_MAX expires without a response strobe.

## Operation
- Synchronisers: `sd_clk_i` and `sd_cmd_i` each pass through 2 flops.
  - rise = sync1 & ~sync2; fall = ~sync1 & sync2.
  - CMD is sampled on rise and driven on fall.
- IDLE: on a rise with CMD = 0 (start bit), clear CRC7 and go to RX.
  - The start bit is fed to the CRC.
- RX: shift 47 more bits on successive rises, MSB first.
  - Bits 47..8 feed the CRC.
  - After the 48th bit, go to CHECK.
- CHECK (1 cycle), evaluated in this order:
  - If the transmission bit (bit 46) ≠ 1 or the end bit ≠ 1: pulse frame_err_o and return to IDLE.
  - Otherwise, if received CRC[7:1] ≠ computed CRC: pulse crc_err_o and return to IDLE.
  - Otherwise: latch idx and arg, pulse cmd_valid_o, clear the fall counter, and go to WAIT.
- WAIT:
  - Count falls, saturating.
  - Accept the first resp_valid_i and latch kind and data.
  - kind none: return to IDLE immediately.
  - If the count reaches NCR_MAX with nothing accepted: pulse resp_timeout_o and return to IDLE.
  - With a response latched and count ≥ NCR_MIN: on the next fall, enter TX and drive the start bit.
  - CMD input is ignored in WAIT (half duplex).
- TX: one bit per fall, with oe = 1.
  - Short response, 48 bits: 0, 0, idx[5:0], arg[31:0], CRC7 over the first 40 bits, 1.
  - Long response, 136 bits: 0, 0, 111111, data[127:1], 1.
  - After the end bit, go to TAIL.
- TAIL: keep cmd_o = 1 for one more fall, then on the following fall set oe = 0 and return to IDLE.
- Rises during TX and TAIL are ignored.
- rst_i at any point: next cycle the block is in IDLE with all outputs at reset values, and any in-progress command or response is discarded.
- A resp_valid_i outside WAIT, or a second one within WAIT, is ignored.

## Timing
- Reset values:
  - sd_cmd_o = 1, sd_cmd_oe = 0.
  - cmd_valid_o, crc_err_o, frame_err_o, resp_timeout_o = 0.
  - cmd_idx_o = 0, cmd_arg_o = 0, busy_o = 0.
- Input latency: 2 clk_i cycles of synchroniser delay from a pin edge to rise/fall detection.
- Command latency: cmd_valid_o is asserted 2 clk_i cycles after the rise that samples the end bit (1 for the shift, 1 for CHECK).
- Response start: the start bit appears at fall number max(NCR_MIN, first fall after the strobe is accepted), counted from CHECK.
- Output register: sd_cmd_o and sd_cmd_oe change in the clk_i cycle after fall detection; both are registered outputs.
- Bit counter: 8 bits, no wrap; TX terminates exactly at 48 or 136 bits.

## Structure
- `neosd_pkg` holds:
  - the resp_kind enum (NONE, SHORT, LONG);
  - the state enum (IDLE, RX, CHECK, WAIT, TX, TAIL);
  - the CRC7 polynomial constant 7'h09.
- Sub-module `neosd_crc7`: serial CRC7 with clear, enable and data-in. It is shared with the host command FSM and instantiated twice here, once for RX and once for TX.

## Test plan
- CMD0, bits 0x40_00000000_95 -> cmd_valid_o with idx 0, arg 0; strobe kind none -> oe never asserted.
- CMD8, 0x48_000001AA_87, followed by short response idx 8, arg 0x1AA -> line carries 0x08_000001AA_13 starting at fall 2 after the end bit; oe drops 1 bit after the end bit.
- CMD8 with the CRC byte sent as 0x89 -> crc_err_o pulses, no cmd_valid_o, busy_o returns to 0.
- Transmission bit cleared (first byte 0x08) -> frame_err_o pulses, no cmd_valid_o.
- CMD2 with a long response, data 128'h0123…EF -> 136 bits: 0, 0, 111111, data[127:1], 1.
- No strobe after a good command -> resp_timeout_o pulses at fall 64.
- rst_i asserted mid-TX -> next cycle oe = 0, cmd_o = 1, state IDLE.

Source files
------------

// File: rtl/neosd_pkg.sv
// Shared types and constants for the SD card-side CMD responder.
package neosd_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } resp_kind_e;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        CHECK,
        WAIT,
        TX,
        TAIL
    } state_e;

    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first. Clear and enable in the same cycle
// restarts the CRC from zero and folds in the current bit.
module neosd_crc7
    import neosd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_base;
    logic       feedback;

    assign crc_base = clr_i ? 7'h00 : crc_q;
    assign feedback = crc_base[6] ^ din_i;
    assign crc_o    = crc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= 7'h00;
        end else if (en_i) begin
            crc_q <= {crc_base[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end else if (clr_i) begin
            crc_q <= 7'h00;
        end
    end

endmodule

// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD responder: receives 48-bit host commands on SD clock rises
// and returns short/long responses on falls with NCR spacing.
module neosd_card_cmd
    import neosd_pkg::*;
#(
    parameter int NCR_MIN = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sd_clk_i,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_idx_o,
    output logic [31:0]  cmd_arg_o,
    input  logic         resp_valid_i,
    input  logic [1:0]   resp_kind_i,
    input  logic [127:0] resp_data_i,
    output logic         busy_o,
    output logic         crc_err_o,
    output logic         frame_err_o,
    output logic         resp_timeout_o
);

    localparam int CW = $clog2(NCR_MAX + 1);
    localparam logic [CW-1:0] NCR_MIN_M1 = CW'(NCR_MIN - 1);
    localparam logic [CW-1:0] NCR_MAX_C  = CW'(NCR_MAX);

    state_e         state_q, state_d;
    logic           clk_s1, clk_s2, cmd_s1, cmd_s2;
    logic           rise, fall, cmd_s;
    logic [47:0]    rx_sr;
    logic [7:0]     rx_cnt;
    logic [6:0]     rx_crc, tx_crc;
    logic [CW-1:0]  fall_cnt;
    logic           resp_held, long_q, tail_q;
    logic [135:0]   tx_sr, tx_eff;
    logic [7:0]     tx_cnt, tx_last;
    logic           start_bit, frame_bad, crc_bad;
    logic           resp_accept, resp_is_none, timeout, tx_go, tx_start;
    logic           rx_crc_en, tx_crc_en;

    assign rise  = clk_s1 & ~clk_s2;
    assign fall  = ~clk_s1 & clk_s2;
    assign cmd_s = cmd_s2;

    assign start_bit    = (state_q == IDLE) && rise && !cmd_s;
    assign frame_bad    = !rx_sr[46] || !rx_sr[0];
    assign crc_bad      = rx_sr[7:1] != rx_crc;
    assign resp_accept  = (state_q == WAIT) && resp_valid_i && !resp_held;
    assign resp_is_none = (resp_kind_i != SHORT) && (resp_kind_i != LONG);
    assign timeout      = !resp_held && !resp_valid_i && (fall_cnt == NCR_MAX_C);
    assign tx_go        = fall && resp_held && (fall_cnt >= NCR_MIN_M1);
    assign tx_start     = (state_q == WAIT) && (state_d == TX);
    assign tx_last      = long_q ? 8'd135 : 8'd47;
    assign busy_o       = state_q != IDLE;

    // Short responses carry their CRC7 in the 7 reserved bits after bit 39.
    assign tx_eff = (state_q == TX && !long_q && tx_cnt == 8'd40)
                  ? {tx_crc, tx_sr[128:0]} : tx_sr;

    assign rx_crc_en = start_bit || ((state_q == RX) && rise && rx_cnt < 8'd40);
    assign tx_crc_en = tx_start || ((state_q == TX) && fall && tx_cnt < 8'd40);

    neosd_crc7 u_rx_crc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_bit),
        .en_i  (rx_crc_en),
        .din_i (cmd_s),
        .crc_o (rx_crc)
    );

    neosd_crc7 u_tx_crc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tx_start),
        .en_i  (tx_crc_en),
        .din_i (tx_eff[135]),
        .crc_o (tx_crc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_bit) state_d = RX;
            RX:    if (rise && rx_cnt == 8'd47) state_d = CHECK;
            CHECK: state_d = (frame_bad || crc_bad) ? IDLE : WAIT;
            WAIT: begin
                if (resp_accept && resp_is_none) state_d = IDLE;
                else if (timeout)                state_d = IDLE;
                else if (tx_go)                  state_d = TX;
            end
            TX:    if (fall && tx_cnt == tx_last) state_d = TAIL;
            TAIL:  if (fall && tail_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_s1 <= 1'b0;  clk_s2 <= 1'b0;
            cmd_s1 <= 1'b1;  cmd_s2 <= 1'b1;
            rx_sr <= '0;     rx_cnt <= '0;
            fall_cnt <= '0;  resp_held <= 1'b0;
            long_q <= 1'b0;  tail_q <= 1'b0;
            tx_sr <= '0;     tx_cnt <= '0;
            sd_cmd_o <= 1'b1;
            sd_cmd_oe <= 1'b0;
            cmd_valid_o <= 1'b0;
            cmd_idx_o <= '0;
            cmd_arg_o <= '0;
            crc_err_o <= 1'b0;
            frame_err_o <= 1'b0;
            resp_timeout_o <= 1'b0;
        end else begin
            clk_s1 <= sd_clk_i;  clk_s2 <= clk_s1;
            cmd_s1 <= sd_cmd_i;  cmd_s2 <= cmd_s1;
            cmd_valid_o <= 1'b0;
            crc_err_o <= 1'b0;
            frame_err_o <= 1'b0;
            resp_timeout_o <= 1'b0;
            case (state_q)
                IDLE: if (start_bit) begin
                    rx_sr  <= {rx_sr[46:0], cmd_s};
                    rx_cnt <= 8'd1;
                end
                RX: if (rise) begin
                    rx_sr  <= {rx_sr[46:0], cmd_s};
                    rx_cnt <= rx_cnt + 8'd1;
                end
                CHECK: begin
                    if (frame_bad) begin
                        frame_err_o <= 1'b1;
                    end else if (crc_bad) begin
                        crc_err_o <= 1'b1;
                    end else begin
                        cmd_idx_o   <= rx_sr[45:40];
                        cmd_arg_o   <= rx_sr[39:8];
                        cmd_valid_o <= 1'b1;
                        fall_cnt    <= '0;
                        resp_held   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (fall && fall_cnt != NCR_MAX_C) fall_cnt <= fall_cnt + CW'(1);
                    if (resp_accept) begin
                        resp_held <= 1'b1;
                        long_q    <= resp_kind_i == LONG;
                        tx_sr     <= (resp_kind_i == LONG)
                            ? {2'b00, 6'h3F, resp_data_i[127:1], 1'b1}
                            : {2'b00, resp_data_i[37:32], resp_data_i[31:0], 7'h00, 1'b1, 88'h0};
                    end
                    if (timeout) resp_timeout_o <= 1'b1;
                    if (tx_start) begin
                        sd_cmd_o  <= tx_eff[135];
                        sd_cmd_oe <= 1'b1;
                        tx_sr     <= tx_eff << 1;
                        tx_cnt    <= 8'd1;
                        tail_q    <= 1'b0;
                    end
                end
                TX: if (fall) begin
                    sd_cmd_o <= tx_eff[135];
                    tx_sr    <= tx_eff << 1;
                    tx_cnt   <= tx_cnt + 8'd1;
                end
                TAIL: if (fall) begin
                    if (tail_q) begin
                        sd_cmd_oe <= 1'b0;
                    end else begin
                        sd_cmd_o <= 1'b1;
                        tail_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Directed bench for neosd_card_cmd: a host model clocks commands in and
// records the card's CMD drive at every SD clock rise.
module tb_neosd_card_cmd;
    import neosd_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         sd_clk = 1'b0;
    logic         sd_cmd = 1'b1;
    logic         resp_valid = 1'b0;
    logic [1:0]   resp_kind = 2'd0;
    logic [127:0] resp_data = '0;
    logic         sd_cmd_o, sd_cmd_oe, cmd_valid_o, busy_o;
    logic         crc_err_o, frame_err_o, resp_timeout_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;

    int vectors = 0;
    int miscompares = 0;
    int fall_total = 0;
    int base = 0;
    int valid_pulses = 0, crc_pulses = 0, frame_pulses = 0, to_pulses = 0;
    int oe_cycles = 0, to_at = 0, oe_snap = 0;
    logic [1:0] line_log [0:4095];

    logic [127:0] long_data;
    logic [135:0] exp_long, rx_bits;
    logic         rx_oe_all;

    neosd_card_cmd dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .sd_clk_i       (sd_clk),
        .sd_cmd_i       (sd_cmd),
        .sd_cmd_o       (sd_cmd_o),
        .sd_cmd_oe      (sd_cmd_oe),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_idx_o      (cmd_idx_o),
        .cmd_arg_o      (cmd_arg_o),
        .resp_valid_i   (resp_valid),
        .resp_kind_i    (resp_kind),
        .resp_data_i    (resp_data),
        .busy_o         (busy_o),
        .crc_err_o      (crc_err_o),
        .frame_err_o    (frame_err_o),
        .resp_timeout_o (resp_timeout_o)
    );

    always #5 clk = ~clk;

    // SD clock at 1/8 of the system clock, offset from the system edges.
    always begin
        repeat (4) @(posedge clk);
        #2 sd_clk = ~sd_clk;
    end

    always @(negedge sd_clk) fall_total = fall_total + 1;
    always @(posedge sd_clk) line_log[fall_total % 4096] = {sd_cmd_oe, sd_cmd_o};

    always @(negedge clk) begin
        if (cmd_valid_o === 1'b1) valid_pulses = valid_pulses + 1;
        if (crc_err_o === 1'b1) crc_pulses = crc_pulses + 1;
        if (frame_err_o === 1'b1) frame_pulses = frame_pulses + 1;
        if (resp_timeout_o === 1'b1) begin
            to_pulses = to_pulses + 1;
            to_at = fall_total;
        end
        if (sd_cmd_oe === 1'b1) oe_cycles = oe_cycles + 1;
    end

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [135:0] observed,
                               input logic [135:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Host drives each bit after an SD clock fall; base marks the end-bit rise.
    task automatic applyStimulus(input logic [47:0] frame);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            #1 sd_cmd = frame[i];
        end
        @(posedge sd_clk);
        base = fall_total;
    endtask

    task automatic give_response(input logic [1:0] kind, input logic [127:0] data);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_valid_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("valid_seen", found, 1);
        if (found) begin
            resp_valid = 1'b1;
            resp_kind  = kind;
            resp_data  = data;
            @(negedge clk);
            resp_valid = 1'b0;
        end
    endtask

    task automatic wait_falls(input int k);
        while (fall_total < base + k) @(negedge sd_clk);
        @(posedge sd_clk);
        #1;
    endtask

    function automatic logic [1:0] log_at(input int k);
        return line_log[(base + k) % 4096];
    endfunction

    task automatic read_resp(input int first, input int nbits,
                             output logic [135:0] bits, output logic oe_all);
        logic [1:0] e;
        bits = '0;
        oe_all = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            e = log_at(first + k);
            bits = {bits[134:0], e[0]};
            oe_all = oe_all & e[1];
        end
    endtask

    initial begin
        long_data = 128'h0123456789ABCDEF0123456789ABCDEF;
        exp_long  = {2'b00, 6'h3F, long_data[127:1], 1'b1};

        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        checkOutput("reset_flags",
                    {sd_cmd_o, sd_cmd_oe, cmd_valid_o, crc_err_o, frame_err_o, resp_timeout_o, busy_o},
                    7'b1000000);
        checkOutput("reset_idx", cmd_idx_o, 0);
        checkOutput("reset_arg", cmd_arg_o, 0);

        // CMD0 answered with kind none
        applyStimulus(48'h40_00000000_95);
        give_response(2'd0, 128'h0);
        wait_falls(10);
        checkOutput("cmd0_idx", cmd_idx_o, 0);
        checkOutput("cmd0_arg", cmd_arg_o, 0);
        checkOutput("cmd0_valid_cnt", valid_pulses, 1);
        checkOutput("cmd0_no_oe", oe_cycles, 0);
        checkOutput("cmd0_busy", busy_o, 0);

        // CMD8 with a short R7-style response
        applyStimulus(48'h48_000001AA_87);
        give_response(2'd1, 128'h08_000001AA);
        checkOutput("cmd8_busy_wait", busy_o, 1);
        wait_falls(52);
        checkOutput("cmd8_idx", cmd_idx_o, 8);
        checkOutput("cmd8_arg", cmd_arg_o, 32'h1AA);
        checkOutput("cmd8_fall1_idle", log_at(1), 2'b01);
        read_resp(2, 48, rx_bits, rx_oe_all);
        checkOutput("cmd8_resp_bits", rx_bits, 48'h08_000001AA_13);
        checkOutput("cmd8_resp_oe", rx_oe_all, 1);
        checkOutput("cmd8_tail_hold", log_at(50), 2'b11);
        checkOutput("cmd8_tail_release", log_at(51), 2'b01);
        checkOutput("cmd8_busy_end", busy_o, 0);

        // CMD8 with a corrupted CRC byte
        applyStimulus(48'h48_000001AA_89);
        wait_falls(3);
        checkOutput("crc_err_cnt", crc_pulses, 1);
        checkOutput("crc_valid_cnt", valid_pulses, 2);
        checkOutput("crc_busy", busy_o, 0);
        checkOutput("crc_idx_held", cmd_idx_o, 8);

        // Transmission bit cleared
        applyStimulus(48'h08_000001AA_87);
        wait_falls(3);
        checkOutput("frame_err_cnt", frame_pulses, 1);
        checkOutput("frame_crc_cnt", crc_pulses, 1);
        checkOutput("frame_valid_cnt", valid_pulses, 2);
        checkOutput("frame_busy", busy_o, 0);

        // CMD2 with a long response
        applyStimulus(48'h42_00000000_4D);
        give_response(2'd2, long_data);
        wait_falls(140);
        checkOutput("cmd2_idx", cmd_idx_o, 2);
        checkOutput("cmd2_fall1_idle", log_at(1), 2'b01);
        read_resp(2, 136, rx_bits, rx_oe_all);
        checkOutput("cmd2_resp_bits", rx_bits, exp_long);
        checkOutput("cmd2_resp_oe", rx_oe_all, 1);
        checkOutput("cmd2_tail_hold", log_at(138), 2'b11);
        checkOutput("cmd2_tail_release", log_at(139), 2'b01);

        // No strobe: timeout at fall 64
        oe_snap = oe_cycles;
        applyStimulus(48'h40_00000000_95);
        wait_falls(70);
        checkOutput("to_cnt", to_pulses, 1);
        checkOutput("to_fall", to_at - base, 64);
        checkOutput("to_valid_cnt", valid_pulses, 4);
        checkOutput("to_no_oe", oe_cycles, oe_snap);
        checkOutput("to_busy", busy_o, 0);

        // Reset in the middle of a short response
        applyStimulus(48'h48_000001AA_87);
        give_response(2'd1, 128'h08_000001AA);
        wait_falls(10);
        checkOutput("rst_oe_in_tx", sd_cmd_oe, 1);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_tx",
                    {sd_cmd_oe, sd_cmd_o, busy_o, cmd_idx_o}, {1'b0, 1'b1, 1'b0, 6'd0});
        @(negedge clk);
        rst_i = 1'b0;
        oe_snap = oe_cycles;

        // Recovery after reset
        applyStimulus(48'h40_00000000_95);
        give_response(2'd3, 128'h0);
        wait_falls(6);
        checkOutput("recover_valid_cnt", valid_pulses, 6);
        checkOutput("recover_no_oe", oe_cycles, oe_snap);
        checkOutput("recover_busy", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
